// File: rtl/ecc_pkg.sv
// Shared ECC core definitions: operand width, modexp controller state encoding and the
// secp256k1 field prime.
package ecc_pkg;

  localparam int unsigned W = 256;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StScan    = 3'd1;
  localparam logic [2:0] StSqrGo   = 3'd2;
  localparam logic [2:0] StSqrWait = 3'd3;
  localparam logic [2:0] StMulGo   = 3'd4;
  localparam logic [2:0] StMulWait = 3'd5;
  localparam logic [2:0] StDone    = 3'd6;

  localparam logic [W-1:0] Secp256k1P =
    256'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f;

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation controller; all products are
// delegated to an external modmul through its start/ready handshake.
module modexp_ctrl
  import ecc_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_base,
  input  logic [W-1:0] i_exp,
  input  logic [W-1:0] i_m,
  output logic [W-1:0] o_p,
  output logic         o_ready,
  output logic         o_mm_start,
  output logic [W-1:0] o_mm_a,
  output logic [W-1:0] o_mm_b,
  output logic [W-1:0] o_mm_m,
  input  logic [W-1:0] i_mm_p,
  input  logic         i_mm_ready
);

  localparam logic [W-1:0] One = {{(W-1){1'b0}}, 1'b1};

  logic [2:0]   r_state;
  logic [W-1:0] r_b;
  logic [W-1:0] r_e;
  logic [W-1:0] r_m;
  logic [W-1:0] r_r;
  logic [7:0]   r_idx;
  logic [W-1:0] r_p;
  logic         r_ready;
  logic         r_mm_start;
  logic [W-1:0] r_mm_a;
  logic [W-1:0] r_mm_b;
  logic [W-1:0] r_mm_m;
  logic         r_seen_low;

  logic w_bit;
  logic w_last;
  logic w_mm_take;

  assign w_bit  = r_e[r_idx];
  assign w_last = (r_idx == 8'd0);
  // A ready level left over from the previous product is only trusted after it drops once.
  assign w_mm_take = !r_mm_start && r_seen_low && i_mm_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_b        <= '0;
      r_e        <= '0;
      r_m        <= '0;
      r_r        <= '0;
      r_idx      <= '0;
      r_p        <= '0;
      r_ready    <= 1'b0;
      r_mm_start <= 1'b0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
      r_mm_m     <= '0;
      r_seen_low <= 1'b0;
    end else begin
      r_mm_start <= 1'b0;
      case (r_state)
        StIdle, StDone: begin
          if (r_state == StDone) begin
            r_p     <= r_r;
            r_ready <= 1'b1;
          end
          if (i_start) begin
            r_b     <= i_base;
            r_e     <= i_exp;
            r_m     <= i_m;
            r_idx   <= 8'(W - 1);
            r_ready <= 1'b0;
            r_state <= StScan;
          end
        end
        StScan: begin
          if (w_bit) begin
            r_r <= r_b;
            if (w_last) begin
              r_state <= StDone;
            end else begin
              r_idx   <= r_idx - 8'd1;
              r_state <= StSqrGo;
            end
          end else if (w_last) begin
            r_r     <= One;
            r_state <= StDone;
          end else begin
            r_idx <= r_idx - 8'd1;
          end
        end
        StSqrGo, StMulGo: begin
          r_mm_a     <= r_r;
          r_mm_b     <= (r_state == StMulGo) ? r_b : r_r;
          r_mm_m     <= r_m;
          r_mm_start <= 1'b1;
          r_seen_low <= 1'b0;
          r_state    <= (r_state == StMulGo) ? StMulWait : StSqrWait;
        end
        StSqrWait, StMulWait: begin
          if (w_mm_take) begin
            r_r <= i_mm_p;
            if ((r_state == StSqrWait) && w_bit) begin
              r_state <= StMulGo;
            end else if (w_last) begin
              r_state <= StDone;
            end else begin
              r_idx   <= r_idx - 8'd1;
              r_state <= StSqrGo;
            end
          end else if (!r_mm_start && !i_mm_ready) begin
            r_seen_low <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_p        = r_p;
  assign o_ready    = r_ready;
  assign o_mm_start = r_mm_start;
  assign o_mm_a     = r_mm_a;
  assign o_mm_b     = r_mm_b;
  assign o_mm_m     = r_mm_m;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl with a behavioural modmul of configurable latency and stale-ready
// behaviour; expected results are queued at start and compared when ready rises.
module tb_modexp_ctrl;
  import ecc_pkg::*;

  localparam logic [W-1:0] Inv2 =
    256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffff7ffffe18;
  localparam logic [W-1:0] BaseOne =
    256'hfd15c0ffee0123456789abcdef0123456789abcdef0123456789abcdef002715;
  localparam logic [W-1:0] Garbage = {8{32'hdeadbeef}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] base_in = '0;
  logic [W-1:0] exp_in = '0;
  logic [W-1:0] m_in = '0;
  logic [W-1:0] p;
  logic         ready;
  logic         mm_start;
  logic [W-1:0] mm_a, mm_b, mm_m;
  logic [W-1:0] mm_p;
  logic         mm_ready;

  int checks = 0;
  int failures = 0;
  int n_pulses = 0;
  int mm_lat = 4;
  int mm_stale = 0;
  logic [W-1:0] exp_q[$];

  logic [W-1:0] mm_prod;
  int           mm_cnt;
  logic         mm_busy;

  always #5 clk = ~clk;

  modexp_ctrl dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_base    (base_in),
    .i_exp     (exp_in),
    .i_m       (m_in),
    .o_p       (p),
    .o_ready   (ready),
    .o_mm_start(mm_start),
    .o_mm_a    (mm_a),
    .o_mm_b    (mm_b),
    .o_mm_m    (mm_m),
    .i_mm_p    (mm_p),
    .i_mm_ready(mm_ready)
  );

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
    logic [2*W-1:0] t;
    t = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    t = t % {{W{1'b0}}, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                              input logic [W-1:0] m);
    logic [W-1:0] r;
    r = {{(W-1){1'b0}}, 1'b1};
    for (int i = W - 1; i >= 0; i--) begin
      r = mulmod(r, r, m);
      if (e[i]) r = mulmod(r, b, m);
    end
    return r;
  endfunction

  // Cycles from the start-sampling edge to ready; modmul ready is seen lat+1 cycles after
  // the mm_start cycle, so each product step costs lat+3 cycles.
  function automatic int expect_cycles(input logic [W-1:0] e, input int lat);
    int k;
    int n;
    if (e == '0) return W + 1;
    k = 0;
    for (int i = 0; i < W; i++) if (e[i]) k = i;
    n = $countones(e) - 1;
    return (W - k) + (k + n) * (lat + 3) + 1;
  endfunction

  function automatic logic [W-1:0] rand_below_p();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[W-33:0], 32'($urandom)};
    if (r >= Secp256k1P) r = r - Secp256k1P;
    return r;
  endfunction

  // Behavioural modmul; mm_stale > 0 keeps ready high with a junk product after start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_ready <= 1'b0;
      mm_p     <= '0;
      mm_prod  <= '0;
      mm_busy  <= 1'b0;
      mm_cnt   <= 0;
    end else if (mm_start) begin
      mm_prod <= mulmod(mm_a, mm_b, mm_m);
      mm_busy <= 1'b1;
      mm_cnt  <= 0;
      if (mm_stale == 0) mm_ready <= 1'b0;
      else mm_p <= Garbage;
    end else if (mm_busy) begin
      mm_cnt <= mm_cnt + 1;
      if (mm_cnt + 1 == mm_stale) mm_ready <= 1'b0;
      if (mm_cnt + 1 == mm_lat) begin
        mm_ready <= 1'b1;
        mm_p     <= mm_prod;
        mm_busy  <= 1'b0;
      end
    end
  end

  always @(posedge clk) if (mm_start === 1'b1) n_pulses++;

  task automatic start_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                          input logic [W-1:0] expv);
    @(negedge clk);
    base_in = b;
    exp_in  = e;
    m_in    = m;
    start   = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input string name, output int cyc);
    bit got;
    logic [W-1:0] want;
    cyc = 0;
    got = 0;
    while (cyc < 20000 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout: ready still %b after %0d cycles, required 1", name, ready, cyc);
    end else if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard: result with no queued expectation, got %h", name, p);
    end else begin
      want = exp_q.pop_front();
      if (p !== want) begin
        failures++;
        $display("FAIL %s_p: got %h required %h", name, p, want);
      end
    end
  endtask

  task automatic wait_mm_start(output bit seen);
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (mm_start === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_mm_start: mm_start never seen, got %b required 1", mm_start);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (p !== '0 || ready !== 1'b0 || mm_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: p=%h ready=%b mm_start=%b required 0/0/0", p, ready,
               mm_start);
    end
    checks++;
    if (mm_a !== '0 || mm_b !== '0 || mm_m !== '0) begin
      failures++;
      $display("FAIL reset_operands: a=%h b=%h m=%h required 0", mm_a, mm_b, mm_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_small();
    int cyc;
    mm_lat = 4;
    n_pulses = 0;
    start_op(256'd3, 256'd5, Secp256k1P, 256'hf3);
    wait_result("small", cyc);
    check_int("small_pulses", n_pulses, 3);
    check_int("small_latency", cyc, expect_cycles(256'd5, mm_lat));
  endtask

  task automatic test_exp_zero_one();
    int cyc;
    logic [W-1:0] b;
    b = rand_below_p();
    n_pulses = 0;
    start_op(b, '0, Secp256k1P, 256'd1);
    wait_result("exp0", cyc);
    check_int("exp0_latency", cyc, W + 1);
    check_int("exp0_pulses", n_pulses, 0);
    n_pulses = 0;
    start_op(BaseOne, 256'd1, Secp256k1P, BaseOne);
    wait_result("exp1", cyc);
    check_int("exp1_pulses", n_pulses, 0);
    check_int("exp1_latency", cyc, W + 1);
  endtask

  task automatic test_inverse();
    int cyc;
    logic [W-1:0] e;
    e = Secp256k1P - 256'd2;
    mm_lat = 3;
    n_pulses = 0;
    start_op(256'd2, e, Secp256k1P, Inv2);
    wait_result("inverse", cyc);
    check_int("inverse_pulses", n_pulses, 255 + $countones(e) - 1);
    check_int("inverse_latency", cyc, expect_cycles(e, mm_lat));
  endtask

  task automatic test_stale_ready();
    int cyc;
    checks++;
    if (mm_ready !== 1'b1) begin
      failures++;
      $display("FAIL stale_precond: mm_ready got %b required 1", mm_ready);
    end
    mm_stale = 3;
    mm_lat = 8;
    n_pulses = 0;
    start_op(256'd3, 256'd5, Secp256k1P, 256'hf3);
    wait_result("stale", cyc);
    check_int("stale_pulses", n_pulses, 3);
    mm_stale = 0;
  endtask

  task automatic test_ignore_start();
    int cyc;
    bit seen;
    mm_lat = 6;
    n_pulses = 0;
    start_op(256'd3, 256'd5, Secp256k1P, 256'hf3);
    wait_mm_start(seen);
    @(negedge clk);
    base_in = 256'd7;
    exp_in  = 256'h1234;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result("ignore", cyc);
    check_int("ignore_pulses", n_pulses, 3);
  endtask

  task automatic test_reset_midop();
    int cyc;
    bit seen;
    logic [W-1:0] b;
    start_op(256'd5, 256'hff, Secp256k1P, ref_modexp(256'd5, 256'hff, Secp256k1P));
    wait_mm_start(seen);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || p !== '0 || mm_start !== 1'b0 || mm_a !== '0) begin
      failures++;
      $display("FAIL midop_reset: ready=%b p=%h mm_start=%b mm_a=%h required all 0", ready, p,
               mm_start, mm_a);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b = rand_below_p();
    mm_lat = 5;
    start_op(b, 256'h0b7d, Secp256k1P, ref_modexp(b, 256'h0b7d, Secp256k1P));
    wait_result("after_reset", cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [W-1:0] b;
    logic [W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      b = rand_below_p();
      e = W'($urandom_range(2, 4095));
      mm_lat = int'($urandom_range(2, 6));
      n_pulses = 0;
      start_op(b, e, Secp256k1P, ref_modexp(b, e, Secp256k1P));
      checks++;
      if (ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_ready_drop: got %b required 0", ready);
      end
      wait_result("b2b", cyc);
      check_int("b2b_latency", cyc, expect_cycles(e, mm_lat));
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_exp_zero_one();
    test_inverse();
    test_stale_ready();
    test_ignore_start();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
